// File: rtl/pkg_display.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package pkg_display;

  localparam int N_DIGITOS = 6;   // scanned positions: 5 BCD digits + sign slot
  localparam int N_ANODOS  = 8;   // physical anodes on the board

  typedef logic [6:0] t_segmentos;

  localparam t_segmentos SEG_0       = 7'b1000000;
  localparam t_segmentos SEG_1       = 7'b1111001;
  localparam t_segmentos SEG_2       = 7'b0100100;
  localparam t_segmentos SEG_3       = 7'b0110000;
  localparam t_segmentos SEG_4       = 7'b0011001;
  localparam t_segmentos SEG_5       = 7'b0010010;
  localparam t_segmentos SEG_6       = 7'b0000010;
  localparam t_segmentos SEG_7       = 7'b1111000;
  localparam t_segmentos SEG_8       = 7'b0000000;
  localparam t_segmentos SEG_9       = 7'b0010000;
  localparam t_segmentos SEG_MENOS   = 7'b0111111;
  localparam t_segmentos SEG_E       = 7'b0000110;
  localparam t_segmentos SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/decodificador_bcd_7seg.sv
// Combinational BCD nibble to seven-segment decoder.
//   nibble_i    : BCD digit; values above 9 decode to 'E'
//   apagado_i   : force all segments off (highest priority)
//   menos_i     : show the minus sign
//   segmentos_o : active-low {g,f,e,d,c,b,a}
module decodificador_bcd_7seg
  import pkg_display::*;
(
  input  logic [3:0] nibble_i,
  input  logic       apagado_i,
  input  logic       menos_i,
  output t_segmentos segmentos_o
);

  always_comb begin
    segmentos_o = SEG_APAGADO;
    if (apagado_i) begin
      segmentos_o = SEG_APAGADO;
    end else if (menos_i) begin
      segmentos_o = SEG_MENOS;
    end else begin
      case (nibble_i)
        4'd0:    segmentos_o = SEG_0;
        4'd1:    segmentos_o = SEG_1;
        4'd2:    segmentos_o = SEG_2;
        4'd3:    segmentos_o = SEG_3;
        4'd4:    segmentos_o = SEG_4;
        4'd5:    segmentos_o = SEG_5;
        4'd6:    segmentos_o = SEG_6;
        4'd7:    segmentos_o = SEG_7;
        4'd8:    segmentos_o = SEG_8;
        4'd9:    segmentos_o = SEG_9;
        default: segmentos_o = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/controlador_display_7seg.sv
// Time-multiplexed driver for an 8-digit common-anode display.
// Captures a 5-digit packed BCD result and its sign on the rising edge of
// done, then scans positions 0..5 with leading-zero blanking and a floating
// minus sign placed just left of the most significant shown digit.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   codigo_BCD : packed BCD, digit k in [4k+3:4k]
//   signo      : 1 = negative, sampled with codigo_BCD
//   done       : load strobe (rising edge)
//   anodos     : active-low digit enables (registered)
//   segmentos  : active-low {g,f,e,d,c,b,a} (registered)
//   cargado    : a result has been captured since reset
module controlador_display_7seg
  import pkg_display::*;
#(
  parameter int N_REFRESCO = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [19:0]         codigo_BCD,
  input  logic                signo,
  input  logic                done,
  output logic [N_ANODOS-1:0] anodos,
  output t_segmentos          segmentos,
  output logic                cargado
);

  localparam int CW = (N_REFRESCO > 1) ? $clog2(N_REFRESCO) : 1;

  logic                done_q;
  logic [19:0]         bcd_q;
  logic                signo_q;
  logic                cargado_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [N_ANODOS-1:0] anodos_q, anodos_d;
  t_segmentos          seg_q, seg_d;

  logic       carga;
  logic [4:0] nz;
  logic [2:0] msd;
  logic       menos;
  logic       apagado;
  logic [3:0] nibble;

  assign carga = done & ~done_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(N_REFRESCO - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(N_DIGITOS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Any nonzero nibble (including invalid ones shown as 'E') keeps its
  // position and everything below it lit.
  always_comb begin
    msd = 3'd0;
    for (int k = 0; k < 5; k++) begin
      nz[k] = |bcd_q[4*k +: 4];
    end
    for (int k = 1; k < 5; k++) begin
      if (nz[k]) msd = 3'(k);
    end
  end

  // A negative zero has no nonzero digit, so no minus is shown for it.
  assign menos   = signo_q & (|nz) & (idx_q == msd + 3'd1);
  assign apagado = ~menos & (idx_q > msd);

  always_comb begin
    case (idx_q)
      3'd0:    nibble = bcd_q[3:0];
      3'd1:    nibble = bcd_q[7:4];
      3'd2:    nibble = bcd_q[11:8];
      3'd3:    nibble = bcd_q[15:12];
      3'd4:    nibble = bcd_q[19:16];
      default: nibble = 4'd0;
    endcase
  end

  decodificador_bcd_7seg u_dec (
    .nibble_i   (nibble),
    .apagado_i  (apagado),
    .menos_i    (menos),
    .segmentos_o(seg_d)
  );

  assign anodos_d = apagado ? {N_ANODOS{1'b1}}
                            : ~({{(N_ANODOS-1){1'b0}}, 1'b1} << idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      bcd_q     <= '0;
      signo_q   <= 1'b0;
      cargado_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      anodos_q  <= {N_ANODOS{1'b1}};
      seg_q     <= SEG_APAGADO;
    end else begin
      done_q   <= done;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodos_q <= anodos_d;
      seg_q    <= seg_d;
      if (carga) begin
        bcd_q     <= codigo_BCD;
        signo_q   <= signo;
        cargado_q <= 1'b1;
      end
    end
  end

  assign anodos    = anodos_q;
  assign segmentos = seg_q;
  assign cargado   = cargado_q;

endmodule

// File: tb/tb_controlador_display_7seg.sv
module tb_controlador_display_7seg;

  localparam int N     = 4;
  localparam int FRAME = 6 * N;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] codigo_BCD;
  logic        signo;
  logic        done;
  logic [7:0]  anodos;
  logic [6:0]  segmentos;
  logic        cargado;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [19:0] m_bcd;
  logic        m_sign;
  logic        m_carg;
  logic        m_prev;
  int          m_edge;

  controlador_display_7seg #(.N_REFRESCO(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .codigo_BCD(codigo_BCD),
    .signo     (signo),
    .done      (done),
    .anodos    (anodos),
    .segmentos (segmentos),
    .cargado   (cargado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] patron(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // What the display should show at position pos for value v / sign s.
  function automatic logic [14:0] esperado(input logic [19:0] v, input logic s, input int pos);
    int dig[5];
    int top;
    bit nonzero;
    logic [7:0] an;
    top = 0;
    nonzero = 0;
    for (int k = 0; k < 5; k++) begin
      dig[k] = int'((v >> (4 * k)) & 20'hF);
      if (dig[k] != 0) begin
        top = k;
        nonzero = 1;
      end
    end
    an = 8'hFF;
    an[pos] = 1'b0;
    if (pos <= top) return {an, patron(dig[pos])};
    if (s && nonzero && pos == top + 1) return {an, 7'b0111111};
    return {8'hFF, 7'h7F};
  endfunction

  task automatic model_reset();
    m_bcd  = '0;
    m_sign = 1'b0;
    m_carg = 1'b0;
    m_prev = 1'b0;
    m_edge = 0;
  endtask

  // one clock: predict, update model with values seen at the edge, check at +1
  task automatic step();
    logic [14:0] e;
    @(posedge clk);
    e = esperado(m_bcd, m_sign, (m_edge / N) % 6);
    if (done && !m_prev) begin
      m_bcd  = codigo_BCD;
      m_sign = signo;
      m_carg = 1'b1;
    end
    m_prev = done;
    m_edge++;
    #1;
    chk("anodos", 32'(anodos), 32'(e[14:7]));
    chk("segmentos", 32'(segmentos), 32'(e[6:0]));
    chk("cargado", 32'(cargado), 32'(m_carg));
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_anodos", 32'(anodos), 32'hFF);
    chk("rst_segmentos", 32'(segmentos), 32'h7F);
    chk("rst_cargado", 32'(cargado), 32'h0);
    #2 reset = 1'b1;
    model_reset();
  endtask

  task automatic load(input logic [19:0] v, input logic s);
    codigo_BCD = v;
    signo = s;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  task automatic frame();
    repeat (FRAME) step();
  endtask

  function automatic logic [19:0] bcd_aleatorio();
    logic [19:0] v;
    int nib;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 1) == 0) nib = 0;
      else if ($urandom_range(0, 7) == 0) nib = int'($urandom_range(10, 15));
      else nib = int'($urandom_range(0, 9));
      v[4*k +: 4] = 4'(nib);
    end
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    done = 1'b0;
    signo = 1'b0;
    codigo_BCD = '0;
    #12;
    chk("init_anodos", 32'(anodos), 32'hFF);
    chk("init_segmentos", 32'(segmentos), 32'h7F);
    chk("init_cargado", 32'(cargado), 32'h0);
    #1 reset = 1'b1;
    model_reset();

    repeat (7) step();
    do_reset();
    repeat (3) step();

    load(20'h00028, 1'b0);
    frame();
    load(20'h00028, 1'b1);
    frame();
    load(20'h00000, 1'b1);
    frame();
    load(20'h1A003, 1'b0);
    frame();
    load(20'h98765, 1'b1);
    frame();

    // done held high: only the first edge loads
    codigo_BCD = 20'h00005;
    signo = 1'b0;
    done = 1'b1;
    repeat (4) step();
    codigo_BCD = 20'h00007;
    repeat (6) step();
    done = 1'b0;
    frame();
    done = 1'b1;
    step();
    done = 1'b0;
    frame();

    // back-to-back 1-0-1 edges
    codigo_BCD = 20'h00011;
    done = 1'b1;
    step();
    done = 1'b0;
    codigo_BCD = 20'h00222;
    signo = 1'b1;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    frame();

    // done edge on the index wrap cycle
    while (m_edge % FRAME != FRAME - 1) step();
    load(20'h03040, 1'b1);
    frame();

    // reset held across an edge while done is high: no capture
    codigo_BCD = 20'h00099;
    done = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rstdone_cargado", 32'(cargado), 32'h0);
    chk("rstdone_anodos", 32'(anodos), 32'hFF);
    done = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    frame();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        codigo_BCD = bcd_aleatorio();
        signo = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) done = ~done;
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
